// File: rtl/text_pkg.sv
// Shared constants for the text window buffer.
// Geometry, fill/control codes, FSM encoding and byte-lane addressing.
package text_pkg;

    localparam int ROWS     = 4;
    localparam int COLS     = 32;
    localparam int ROW_BITS = 256;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_FIRST = 8'h20;
    localparam logic [7:0] ASCII_LAST  = 8'h7E;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;

    // MSB of the byte at (row, col); row 0 col 0 is the top byte.
    function automatic logic [9:0] char_msb(
        input logic [1:0] row,
        input logic [4:0] col
    );
        return 10'd1023
             - {row, 8'd0}
             - {2'd0, col, 3'd0};
    endfunction

endpackage

// File: rtl/cursor_blinker.sv
// Cursor blink phase generator.
// Ports: clk, reset_n (sync, active-low), restart (force visible), blink.
module cursor_blinker #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic blink
);

    localparam int CW =
        (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            blink <= 1'b1;
        end else if (restart) begin
            cnt_q <= '0;
            blink <= 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            blink <= ~blink;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Character buffer controller for the on-screen text window.
// Ports: byte stream in (in_data/in_valid/in_ready), clear_req pulse,
// ascii_flat buffer, cursor_row/col, cursor_blink, busy.
module text_buffer_ctrl #(
    parameter int         ROWS         = 4,
    parameter int         COLS         = 32,
    parameter int         BLINK_CYCLES = 25_000_000,
    parameter logic [7:0] FILL_CHAR    = 8'h20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear_req,
    output logic [ROWS*COLS*8-1:0] ascii_flat,
    output logic [1:0]             cursor_row,
    output logic [4:0]             cursor_col,
    output logic                   cursor_blink,
    output logic                   busy
);
    import text_pkg::*;

    localparam int         BW       = ROWS * COLS * 8;
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    logic [BW-1:0] buf_q;
    logic [1:0]    state_q, state_d;
    logic          pend_q;
    logic [1:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic [1:0]    clr_q, clr_d;

    logic          accept, start_clr;
    logic          is_print, is_lf, is_cr, is_bs;
    logic          wr_en;
    logic [1:0]    wr_row;
    logic [4:0]    wr_col;
    logic [7:0]    wr_char;

    assign in_ready  = (state_q == ST_IDLE) & ~pend_q;
    assign accept    = in_valid & in_ready;
    assign start_clr = (state_q == ST_IDLE) & pend_q;
    assign busy      = (state_q == ST_SCROLL)
                     | (state_q == ST_CLEAR);

    assign is_print = (in_data >= ASCII_FIRST)
                    & (in_data <= ASCII_LAST);
    assign is_lf    = (in_data == ASCII_LF);
    assign is_cr    = (in_data == ASCII_CR);
    assign is_bs    = (in_data == ASCII_BS)
                    | (in_data == ASCII_DEL);

    assign ascii_flat = buf_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        clr_d   = clr_q;
        wr_en   = 1'b0;
        wr_row  = row_q;
        wr_col  = col_q;
        wr_char = in_data;
        unique case (1'b1)
            (state_q == ST_SCROLL): begin
                state_d = ST_IDLE;
            end
            (state_q == ST_CLEAR): begin
                if (clr_q == LAST_ROW)
                    state_d = ST_IDLE;
                else
                    clr_d = clr_q + 2'd1;
            end
            start_clr: begin
                state_d = ST_CLEAR;
                row_d   = '0;
                col_d   = '0;
                clr_d   = '0;
            end
            accept: begin
                unique case (1'b1)
                    is_print: begin
                        wr_en = 1'b1;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 5'd1;
                        end else if (row_q != LAST_ROW) begin
                            row_d = row_q + 2'd1;
                            col_d = '0;
                        end else begin
                            col_d   = '0;
                            state_d = ST_SCROLL;
                        end
                    end
                    is_lf: begin
                        col_d = '0;
                        if (row_q != LAST_ROW)
                            row_d = row_q + 2'd1;
                        else
                            state_d = ST_SCROLL;
                    end
                    is_cr: begin
                        col_d = '0;
                    end
                    is_bs: begin
                        if (col_q != 5'd0) begin
                            col_d   = col_q - 5'd1;
                            wr_en   = 1'b1;
                            wr_col  = col_q - 5'd1;
                            wr_char = FILL_CHAR;
                        end else if (row_q != 2'd0) begin
                            row_d   = row_q - 2'd1;
                            col_d   = LAST_COL;
                            wr_en   = 1'b1;
                            wr_row  = row_q - 2'd1;
                            wr_col  = LAST_COL;
                            wr_char = FILL_CHAR;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            // A new request wins over consumption so none is lost.
            pend_q  <= clear_req | (pend_q & ~start_clr);
            row_q   <= row_d;
            col_q   <= col_d;
            clr_q   <= clr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q <= {(ROWS * COLS){FILL_CHAR}};
        end else if (state_q == ST_SCROLL) begin
            buf_q <= {buf_q[BW-ROW_BITS-1:0],
                      {COLS{FILL_CHAR}}};
        end else if (state_q == ST_CLEAR) begin
            buf_q[char_msb(clr_q, 5'd0) -: ROW_BITS]
                <= {COLS{FILL_CHAR}};
        end else if (wr_en) begin
            buf_q[char_msb(wr_row, wr_col) -: 8] <= wr_char;
        end
    end

    cursor_blinker #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(accept),
        .blink  (cursor_blink)
    );

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl.
// Cursor expectations queued at drive time, popped on each handshake.
module tb_text_buffer_ctrl;
    import text_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic          clear_req = 1'b0;
    logic [7:0]    in_data   = 8'h00;
    logic          in_ready;
    logic          cursor_blink;
    logic          busy;
    logic [1023:0] ascii_flat;
    logic [1:0]    cursor_row;
    logic [4:0]    cursor_col;

    text_buffer_ctrl #(
        .BLINK_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .clear_req   (clear_req),
        .ascii_flat  (ascii_flat),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .cursor_blink(cursor_blink),
        .busy        (busy)
    );

    typedef struct packed {
        logic [1:0] r;
        logic [4:0] c;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         stalls = 0;
    logic [7:0] mbuf [4][32];
    int         mr = 0;
    int         mc = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dut_ch(input int r,
                                          input int c);
        return ascii_flat[1023 - 256*r - 8*c -: 8];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                mbuf[r][c] = 8'h20;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 32; c++)
                mbuf[r][c] = mbuf[r+1][c];
        for (int c = 0; c < 32; c++)
            mbuf[3][c] = 8'h20;
    endtask

    task automatic model_put(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mbuf[mr][mc] = b;
            if (mc < 31) mc++;
            else if (mr < 3) begin mr++; mc = 0; end
            else begin mc = 0; model_scroll(); end
        end else if (b == 8'h0A) begin
            mc = 0;
            if (mr < 3) mr++;
            else model_scroll();
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mc > 0) begin
                mc--;
                mbuf[mr][mc] = 8'h20;
            end else if (mr > 0) begin
                mr--;
                mc = 31;
                mbuf[mr][mc] = 8'h20;
            end
        end
    endtask

    task automatic cmp_buf(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                check($sformatf("%s[%0d][%0d]", tag, r, c),
                      32'(dut_ch(r, c)),
                      32'(mbuf[r][c]));
    endtask

    task automatic push_exp();
        exp_t e;
        e.r = 2'(mr);
        e.c = 5'(mc);
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        model_put(b);
        push_exp();
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            stalls++;
            tick();
            k++;
        end
        if (!in_ready) begin
            check("rdy_timeout", 32'(in_ready), 32'd1);
            void'(sb.pop_back());
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready)
            check("settle", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        clear_req = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic fill_rows();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                send(8'(8'h61 + r));
    endtask

    always @(posedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            #1;
            if (sb.size() == 0) begin
                check("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("cur_row", 32'(cursor_row), 32'(mon_e.r));
                check("cur_col", 32'(cursor_col), 32'(mon_e.c));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by 1ms");
        $fatal(1);
    end

    initial begin
        #1;
        reset_n = 1'b0;
        tick();
        tick();
        model_reset();
        check("rst_rdy",   32'(in_ready),     32'd1);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_row",   32'(cursor_row),   32'd0);
        check("rst_col",   32'(cursor_col),   32'd0);
        check("rst_blink", 32'(cursor_blink), 32'd1);
        cmp_buf("rst_buf");
        reset_n = 1'b1;

        send(8'h48);
        send(8'h69);
        cmp_buf("hi_buf");

        do_reset();
        stalls = 0;
        for (int i = 0; i < 32; i++) send(8'h41);
        send(8'h42);
        check("wrap_stalls", 32'(stalls), 32'd0);
        cmp_buf("wrap_buf");

        do_reset();
        fill_rows();
        check("scr_busy", 32'(busy),     32'd1);
        check("scr_rdy",  32'(in_ready), 32'd0);
        tick();
        check("scr_done_busy", 32'(busy),     32'd0);
        check("scr_done_rdy",  32'(in_ready), 32'd1);
        cmp_buf("scr_buf");
        send(8'h65);
        cmp_buf("scr_e_buf");

        do_reset();
        for (int i = 0; i < 31; i++) send(8'h2E);
        send(8'h5A);
        send(8'h08);
        cmp_buf("bs_wrap_buf");
        send(8'h0D);
        send(8'h08);
        cmp_buf("bs_home_buf");
        send(8'h0A);
        send(8'h79);
        send(8'h7F);
        send(8'h01);
        send(8'h0A);
        send(8'h0A);
        send(8'h77);
        send(8'h0A);
        settle();
        cmp_buf("lf_scr_buf");

        do_reset();
        fill_rows();
        in_data   = 8'h51;
        in_valid  = 1'b1;
        clear_req = 1'b1;
        check("clr_scr_busy", 32'(busy),     32'd1);
        check("clr_scr_rdy",  32'(in_ready), 32'd0);
        tick();
        clear_req = 1'b0;
        check("clr_pend_rdy",  32'(in_ready), 32'd0);
        check("clr_pend_busy", 32'(busy),     32'd0);
        tick();
        check("clr_ent_row", 32'(cursor_row), 32'd0);
        check("clr_ent_col", 32'(cursor_col), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("clr_busy", 32'(busy),     32'd1);
            check("clr_rdy",  32'(in_ready), 32'd0);
            tick();
        end
        check("clr_done_rdy",  32'(in_ready), 32'd1);
        check("clr_done_busy", 32'(busy),     32'd0);
        model_reset();
        cmp_buf("clr_buf");
        model_put(8'h51);
        push_exp();
        tick();
        in_valid = 1'b0;
        cmp_buf("clr_q_buf");

        do_reset();
        for (int k = 1; k <= 14; k++) begin
            tick();
            check("blink_run", 32'(cursor_blink),
                  32'(((k / 4) % 2) == 0));
        end
        send(8'h6B);
        check("blink_restart", 32'(cursor_blink), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("blink_after", 32'(cursor_blink),
                  32'(((k / 4) % 2) == 0));
        end

        send(8'h0A);
        send(8'h0A);
        send(8'h0A);
        send(8'h7A);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        check("mid_clr_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        model_reset();
        check("abort_rdy",   32'(in_ready),     32'd1);
        check("abort_busy",  32'(busy),         32'd0);
        check("abort_row",   32'(cursor_row),   32'd0);
        check("abort_col",   32'(cursor_col),   32'd0);
        check("abort_blink", 32'(cursor_blink), 32'd1);
        cmp_buf("abort_buf");
        reset_n = 1'b1;
        tick();
        tick();
        check("abort_idle_busy", 32'(busy),     32'd0);
        check("abort_idle_rdy",  32'(in_ready), 32'd1);

        check("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
